// File: rtl/axi_slave_ram.sv
// ---------------------------------------------------------------------------
// axi_slave_ram
//
// AXI4 responder memory sitting at the far end of the core's AXI master port.
// A dual-port word array is served by two independent engines: a write engine
// (AW -> W beats -> B) and a read engine (AR -> fetch/data beats -> R).
// FIXED and INCR bursts are supported, with WRAP handled as INCR. Transfer
// size is always one 32-bit word. Beats outside the mapped window are
// suppressed (write) or return zero (read) and are flagged with SLVERR.
//
// Ports:
//   CLK, RST                      clock (rising edge), async active-low reset
//   S_AXI_AW*  (ID/ADDR/LEN/BURST/VALID in, READY out)  write address channel
//   S_AXI_W*   (DATA/STRB/LAST/VALID in, READY out)     write data channel
//   S_AXI_B*   (ID/RESP/VALID out, READY in)            write response channel
//   S_AXI_AR*  (ID/ADDR/LEN/BURST/VALID in, READY out)  read address channel
//   S_AXI_R*   (ID/DATA/RESP/LAST/VALID out, READY in)  read data channel
//
// Parameters:
//   BASE_ADDR  byte address of word 0
//   DEPTH      number of 32-bit words (power of two)
// ---------------------------------------------------------------------------
module axi_slave_ram #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DEPTH     = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        S_AXI_AWID,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic        S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic        S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic        S_AXI_RID,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rState_t;

    logic [31:0]      r_mem [DEPTH];
    logic [31:0]      r_ramQ;
    logic             r_live;

    wState_t          r_wState;
    wState_t          w_wNext;
    logic [31:0]      r_wAddr;
    logic [7:0]       r_wLen;
    logic [7:0]       r_wCnt;
    logic             r_wFixed;
    logic             r_wId;
    logic             r_wErr;

    rState_t          r_rState;
    rState_t          w_rNext;
    logic [31:0]      r_rAddr;
    logic [7:0]       r_rLen;
    logic [7:0]       r_rCnt;
    logic             r_rFixed;
    logic             r_rId;

    logic             w_awHs;
    logic             w_wHs;
    logic             w_wFinal;
    logic             w_wEnd;
    logic [31:0]      w_wOff;
    logic             w_wInRange;
    logic [IDX_W-1:0] w_wIdx;

    logic             w_arHs;
    logic             w_rHs;
    logic             w_rLast;
    logic [31:0]      w_rOff;
    logic             w_rInRange;
    logic [IDX_W-1:0] w_rIdx;

    // Handshakes and address decode. The subtraction wraps for addresses
    // below BASE_ADDR, so a single unsigned compare covers both bounds.
    assign w_awHs     = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_wHs      = S_AXI_WVALID & S_AXI_WREADY;
    assign w_wFinal   = (r_wCnt == r_wLen);
    assign w_wEnd     = w_wHs & (w_wFinal | S_AXI_WLAST);
    assign w_wOff     = r_wAddr - BASE_ADDR;
    assign w_wInRange = ({1'b0, w_wOff} < SPAN);
    assign w_wIdx     = w_wOff[IDX_W+1:2];

    assign w_arHs     = S_AXI_ARVALID & S_AXI_ARREADY;
    assign w_rHs      = S_AXI_RVALID & S_AXI_RREADY;
    assign w_rLast    = (r_rCnt == r_rLen);
    assign w_rOff     = r_rAddr - BASE_ADDR;
    assign w_rInRange = ({1'b0, w_rOff} < SPAN);
    assign w_rIdx     = w_rOff[IDX_W+1:2];

    // Holds both address READYs low while reset is asserted and releases
    // them on the first clock edge after reset goes away.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Write engine state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wState <= W_IDLE;
        end else begin
            r_wState <= w_wNext;
        end
    end

    // Write engine next state. A burst ends either when the beat counter
    // reaches the programmed length or when the master raises WLAST early.
    always_comb begin
        w_wNext = r_wState;
        case (r_wState)
            W_IDLE:  if (w_awHs)       w_wNext = W_DATA;
            W_DATA:  if (w_wEnd)       w_wNext = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_wNext = W_IDLE;
            default:                   w_wNext = W_IDLE;
        endcase
    end

    // Write engine outputs, decoded from state and latched fields only so
    // that READY never depends on VALID in the same cycle.
    always_comb begin
        S_AXI_AWREADY = (r_wState == W_IDLE) && r_live;
        S_AXI_WREADY  = (r_wState == W_DATA);
        S_AXI_BVALID  = (r_wState == W_RESP);
        S_AXI_BID     = (r_wState == W_RESP) ? r_wId : 1'b0;
        S_AXI_BRESP   = ((r_wState == W_RESP) && r_wErr) ? 2'b10 : 2'b00;
    end

    // Write burst bookkeeping: latch the AW fields, then count beats and
    // step the address. Any out-of-range beat or a WLAST that disagrees
    // with the beat counter poisons the response with SLVERR.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wAddr  <= 32'd0;
            r_wLen   <= 8'd0;
            r_wCnt   <= 8'd0;
            r_wFixed <= 1'b0;
            r_wId    <= 1'b0;
            r_wErr   <= 1'b0;
        end else if (w_awHs) begin
            r_wAddr  <= S_AXI_AWADDR;
            r_wLen   <= S_AXI_AWLEN;
            r_wCnt   <= 8'd0;
            r_wFixed <= (S_AXI_AWBURST == 2'b00);
            r_wId    <= S_AXI_AWID;
            r_wErr   <= 1'b0;
        end else if (w_wHs) begin
            r_wCnt  <= r_wCnt + 8'd1;
            r_wAddr <= r_wFixed ? r_wAddr : r_wAddr + 32'd4;
            if (!w_wInRange || (S_AXI_WLAST != w_wFinal)) begin
                r_wErr <= 1'b1;
            end
        end
    end

    // The word array itself: byte-masked write port and a read port that
    // only samples during the fetch cycle, so RDATA stays put while the
    // master stalls even if the same word is being rewritten meanwhile.
    // A same-cycle read and write of one word returns the old contents.
    always_ff @(posedge CLK) begin
        if (w_wHs && w_wInRange) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    r_mem[w_wIdx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
        if (r_rState == R_FETCH) begin
            r_ramQ <= r_mem[w_rIdx];
        end
    end

    // Read engine state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rState <= R_IDLE;
        end else begin
            r_rState <= w_rNext;
        end
    end

    // Read engine next state. Every beat spends one cycle in fetch for the
    // synchronous RAM read, giving one beat per two cycles at best.
    always_comb begin
        w_rNext = r_rState;
        case (r_rState)
            R_IDLE:  if (w_arHs) w_rNext = R_FETCH;
            R_FETCH:             w_rNext = R_DATA;
            R_DATA:  if (S_AXI_RREADY) w_rNext = w_rLast ? R_IDLE : R_FETCH;
            default:             w_rNext = R_IDLE;
        endcase
    end

    // Read engine outputs. Out-of-range beats present zero data and SLVERR.
    always_comb begin
        S_AXI_ARREADY = (r_rState == R_IDLE) && r_live;
        S_AXI_RVALID  = (r_rState == R_DATA);
        S_AXI_RID     = (r_rState == R_DATA) ? r_rId : 1'b0;
        S_AXI_RDATA   = ((r_rState == R_DATA) && w_rInRange) ? r_ramQ : 32'd0;
        S_AXI_RRESP   = ((r_rState == R_DATA) && !w_rInRange) ? 2'b10 : 2'b00;
        S_AXI_RLAST   = (r_rState == R_DATA) && w_rLast;
    end

    // Read burst bookkeeping: latch the AR fields, then advance the beat
    // counter and address after every accepted non-final beat.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rAddr  <= 32'd0;
            r_rLen   <= 8'd0;
            r_rCnt   <= 8'd0;
            r_rFixed <= 1'b0;
            r_rId    <= 1'b0;
        end else if (w_arHs) begin
            r_rAddr  <= S_AXI_ARADDR;
            r_rLen   <= S_AXI_ARLEN;
            r_rCnt   <= 8'd0;
            r_rFixed <= (S_AXI_ARBURST == 2'b00);
            r_rId    <= S_AXI_ARID;
        end else if (w_rHs && !w_rLast) begin
            r_rCnt  <= r_rCnt + 8'd1;
            r_rAddr <= r_rFixed ? r_rAddr : r_rAddr + 32'd4;
        end
    end

endmodule

// File: tb/tb_axi_slave_ram.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_ram
//
// Self-checking bench for axi_slave_ram. A word-array reference model is
// updated beat by beat from the AXI burst rules (start address, FIXED/INCR
// stepping, strobes, address window) and every response from the DUT is
// compared against it through checkOutput.
// ---------------------------------------------------------------------------
module tb_axi_slave_ram;

    localparam int DEPTH   = 4096;
    localparam int TIMEOUT = 200;

    logic        CLK;
    logic        RST;
    logic        S_AXI_AWID;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic [1:0]  S_AXI_AWBURST;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic        S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic        S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic        S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    int          vectorsApplied = 0;
    int          miscompares    = 0;

    logic [31:0] refMem [DEPTH];
    logic [31:0] wrData [256];
    logic [3:0]  wrStrb [256];

    axi_slave_ram #(.BASE_ADDR(32'h0), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    // Free-running 100 MHz clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case some handshake never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, observed hang, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Byte address of beat i of a burst.
    function automatic logic [31:0] beatAddr(input logic [31:0] start, input logic [1:0] burst, input int i);
        return (burst == 2'b00) ? start : start + 32'(4 * i);
    endfunction

    function automatic bit refInRange(input logic [31:0] a);
        return a < 32'(4 * DEPTH);
    endfunction

    // Full write transaction; earlyLast >= 0 raises WLAST on that beat index
    // and stops there. bDelay holds BREADY low for that many cycles.
    task automatic applyStimulus(input logic id, input logic [31:0] addr, input int len,
                                 input logic [1:0] burst, input int earlyLast, input int bDelay);
        int          beats;
        int          guard;
        logic        expErr;
        logic [31:0] a;
        beats  = (earlyLast >= 0) ? earlyLast + 1 : len + 1;
        expErr = (earlyLast >= 0);
        S_AXI_AWID    = id;
        S_AXI_AWADDR  = addr;
        S_AXI_AWLEN   = 8'(len);
        S_AXI_AWBURST = burst;
        S_AXI_AWVALID = 1'b1;
        guard = 0;
        while (!S_AXI_AWREADY && guard < TIMEOUT) begin @(posedge CLK); #1; guard++; end
        checkOutput("awReadyTimeout", 64'(guard >= TIMEOUT), 64'd0);
        @(posedge CLK); #1;
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < beats; i++) begin
            if ($urandom_range(3) == 0) begin
                S_AXI_WVALID = 1'b0;
                @(posedge CLK); #1;
            end
            S_AXI_WDATA  = wrData[i];
            S_AXI_WSTRB  = wrStrb[i];
            S_AXI_WLAST  = (earlyLast >= 0) ? (i == earlyLast) : (i == len);
            S_AXI_WVALID = 1'b1;
            guard = 0;
            while (!S_AXI_WREADY && guard < TIMEOUT) begin @(posedge CLK); #1; guard++; end
            checkOutput("wReadyTimeout", 64'(guard >= TIMEOUT), 64'd0);
            @(posedge CLK); #1;
            a = beatAddr(addr, burst, i);
            if (refInRange(a)) begin
                for (int b = 0; b < 4; b++) begin
                    if (wrStrb[i][b]) refMem[a[13:2]][8*b +: 8] = wrData[i][8*b +: 8];
                end
            end else begin
                expErr = 1'b1;
            end
        end
        S_AXI_WVALID = 1'b0;
        S_AXI_WLAST  = 1'b0;
        guard = 0;
        while (!S_AXI_BVALID && guard < TIMEOUT) begin @(posedge CLK); #1; guard++; end
        checkOutput("bValidTimeout", 64'(guard >= TIMEOUT), 64'd0);
        for (int d = 0; d < bDelay; d++) begin
            checkOutput("bValidHeld", 64'(S_AXI_BVALID), 64'd1);
            checkOutput("awReadyLowInResp", 64'(S_AXI_AWREADY), 64'd0);
            @(posedge CLK); #1;
        end
        checkOutput("bid", 64'(S_AXI_BID), 64'(id));
        checkOutput("bresp", 64'(S_AXI_BRESP), expErr ? 64'd2 : 64'd0);
        S_AXI_BREADY = 1'b1;
        @(posedge CLK); #1;
        S_AXI_BREADY = 1'b0;
        checkOutput("bValidDrop", 64'(S_AXI_BVALID), 64'd0);
        checkOutput("awReadyBack", 64'(S_AXI_AWREADY), 64'd1);
    endtask

    // Full read transaction checked beat by beat against the model. With
    // stall set, RREADY is held low for random cycles while the beat must
    // stay unchanged.
    task automatic axiRead(input logic id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input bit stall, input bit checkLat);
        int          guard;
        int          n;
        logic [31:0] a;
        logic [31:0] expData;
        logic [1:0]  expResp;
        S_AXI_ARID    = id;
        S_AXI_ARADDR  = addr;
        S_AXI_ARLEN   = 8'(len);
        S_AXI_ARBURST = burst;
        S_AXI_ARVALID = 1'b1;
        guard = 0;
        while (!S_AXI_ARREADY && guard < TIMEOUT) begin @(posedge CLK); #1; guard++; end
        checkOutput("arReadyTimeout", 64'(guard >= TIMEOUT), 64'd0);
        @(posedge CLK); #1;
        S_AXI_ARVALID = 1'b0;
        if (checkLat) begin
            checkOutput("rValidOneAfterAr", 64'(S_AXI_RVALID), 64'd0);
            @(posedge CLK); #1;
            checkOutput("rValidTwoAfterAr", 64'(S_AXI_RVALID), 64'd1);
        end
        for (int i = 0; i <= len; i++) begin
            guard = 0;
            while (!S_AXI_RVALID && guard < TIMEOUT) begin @(posedge CLK); #1; guard++; end
            checkOutput("rValidTimeout", 64'(guard >= TIMEOUT), 64'd0);
            a       = beatAddr(addr, burst, i);
            expData = refInRange(a) ? refMem[a[13:2]] : 32'd0;
            expResp = refInRange(a) ? 2'b00 : 2'b10;
            if (stall) begin
                n = $urandom_range(3);
                for (int k = 0; k < n; k++) begin
                    S_AXI_RREADY = 1'b0;
                    @(posedge CLK); #1;
                    checkOutput("rdataStable", 64'(S_AXI_RDATA), 64'(expData));
                    checkOutput("rvalidStable", 64'(S_AXI_RVALID), 64'd1);
                end
            end
            checkOutput($sformatf("rdata@%0h", a), 64'(S_AXI_RDATA), 64'(expData));
            checkOutput("rresp", 64'(S_AXI_RRESP), 64'(expResp));
            checkOutput("rlast", 64'(S_AXI_RLAST), 64'(i == len));
            checkOutput("rid", 64'(S_AXI_RID), 64'(id));
            S_AXI_RREADY = 1'b1;
            @(posedge CLK); #1;
            S_AXI_RREADY = 1'b0;
        end
    endtask

    // Main sequence: reset, fill memory, directed cases, then random traffic.
    initial begin
        int          guard;
        logic [31:0] rAddr;
        int          rLen;
        logic [1:0]  rBurst;

        RST = 1'b0;
        S_AXI_AWID = 0; S_AXI_AWADDR = 0; S_AXI_AWLEN = 0; S_AXI_AWBURST = 0; S_AXI_AWVALID = 0;
        S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WLAST = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
        S_AXI_ARID = 0; S_AXI_ARADDR = 0; S_AXI_ARLEN = 0; S_AXI_ARBURST = 0; S_AXI_ARVALID = 0;
        S_AXI_RREADY = 0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("resetRvalid", 64'(S_AXI_RVALID), 64'd0);
        checkOutput("resetBvalid", 64'(S_AXI_BVALID), 64'd0);
        checkOutput("resetRdata", 64'(S_AXI_RDATA), 64'd0);
        checkOutput("resetBresp", 64'(S_AXI_BRESP), 64'd0);
        checkOutput("resetWready", 64'(S_AXI_WREADY), 64'd0);
        #4 RST = 1'b1;
        @(posedge CLK); #1;
        checkOutput("awReadyAfterReset", 64'(S_AXI_AWREADY), 64'd1);
        checkOutput("arReadyAfterReset", 64'(S_AXI_ARREADY), 64'd1);

        // Fill every word so the model and RAM agree everywhere.
        for (int blk = 0; blk < DEPTH / 256; blk++) begin
            for (int i = 0; i < 256; i++) begin wrData[i] = $urandom; wrStrb[i] = 4'hF; end
            applyStimulus(1'b0, 32'(blk * 1024), 255, 2'b01, -1, 0);
        end

        // Single write then read with latency check.
        wrData[0] = 32'hDEADBEEF; wrStrb[0] = 4'hF;
        applyStimulus(1'b1, 32'h10, 0, 2'b01, -1, 0);
        axiRead(1'b1, 32'h10, 0, 2'b01, 1'b0, 1'b1);

        // INCR burst 1..4, then FIXED burst 1..4 collapsing on one word.
        for (int i = 0; i < 4; i++) begin wrData[i] = 32'(i + 1); wrStrb[i] = 4'hF; end
        applyStimulus(1'b0, 32'h100, 3, 2'b01, -1, 0);
        axiRead(1'b0, 32'h100, 3, 2'b01, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h200, 3, 2'b00, -1, 0);
        axiRead(1'b1, 32'h200, 0, 2'b01, 1'b0, 1'b0);
        checkOutput("fixedModelWord", 64'(refMem[32'h200 >> 2]), 64'd4);

        // Byte strobes.
        wrData[0] = 32'h11223344; wrStrb[0] = 4'hF;
        applyStimulus(1'b0, 32'h20, 0, 2'b01, -1, 0);
        wrData[0] = 32'hAABBCCDD; wrStrb[0] = 4'b0101;
        applyStimulus(1'b0, 32'h20, 0, 2'b01, -1, 0);
        axiRead(1'b0, 32'h20, 0, 2'b01, 1'b0, 1'b0);

        // Out of range write must not alias onto word 0; read across the top.
        wrData[0] = 32'hBAD0BAD0; wrStrb[0] = 4'hF;
        applyStimulus(1'b1, 32'h4000, 0, 2'b01, -1, 0);
        axiRead(1'b0, 32'h0, 0, 2'b01, 1'b0, 1'b0);
        axiRead(1'b1, 32'h3FFC, 1, 2'b01, 1'b1, 1'b0);

        // Early WLAST on beat index 1 of a len=3 burst, then B stall.
        for (int i = 0; i < 4; i++) begin wrData[i] = $urandom; wrStrb[i] = 4'hF; end
        applyStimulus(1'b0, 32'h300, 3, 2'b01, 1, 0);
        axiRead(1'b0, 32'h300, 3, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h340, 0, 2'b01, -1, 5);

        // Overlapping len=7 write and read on disjoint regions (WRAP as INCR).
        for (int i = 0; i < 8; i++) begin wrData[i] = $urandom; wrStrb[i] = 4'($urandom); end
        fork
            applyStimulus(1'b1, 32'h400, 7, 2'b10, -1, 0);
            axiRead(1'b0, 32'h800, 7, 2'b01, 1'b1, 1'b0);
        join
        axiRead(1'b1, 32'h400, 7, 2'b01, 1'b0, 1'b0);

        // Reset in the middle of a read burst.
        S_AXI_ARID = 1'b0; S_AXI_ARADDR = 32'h100; S_AXI_ARLEN = 8'd7;
        S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
        guard = 0;
        while (!S_AXI_ARREADY && guard < TIMEOUT) begin @(posedge CLK); #1; guard++; end
        @(posedge CLK); #1;
        S_AXI_ARVALID = 1'b0;
        guard = 0;
        while (!S_AXI_RVALID && guard < TIMEOUT) begin @(posedge CLK); #1; guard++; end
        checkOutput("midResetReach", 64'(S_AXI_RVALID), 64'd1);
        #2 RST = 1'b0;
        #1;
        checkOutput("rValidDuringReset", 64'(S_AXI_RVALID), 64'd0);
        checkOutput("rLastDuringReset", 64'(S_AXI_RLAST), 64'd0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
        @(posedge CLK); #1;
        checkOutput("arReadyAfterMidReset", 64'(S_AXI_ARREADY), 64'd1);
        checkOutput("awReadyAfterMidReset", 64'(S_AXI_AWREADY), 64'd1);
        axiRead(1'b1, 32'h100, 3, 2'b01, 1'b1, 1'b1);

        // Random traffic, occasionally straddling the top of the window.
        for (int t = 0; t < 40; t++) begin
            rAddr  = ($urandom_range(9) == 0) ? 32'($urandom_range(32'h3FE0, 32'h4010))
                                              : 32'($urandom_range(0, 32'h3FFF));
            rLen   = $urandom_range(7);
            rBurst = 2'($urandom_range(2));
            if ($urandom_range(1) == 0) begin
                for (int i = 0; i <= rLen; i++) begin wrData[i] = $urandom; wrStrb[i] = 4'($urandom); end
                applyStimulus(1'($urandom), rAddr, rLen, rBurst, -1, $urandom_range(2));
            end else begin
                axiRead(1'($urandom), rAddr, rLen, rBurst, 1'($urandom), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
